mmio_bridge: RTL and testbench

- Data-side bus bridge between the CPU memory stage and the data RAM and I/O peripherals (timer, LEDs, 7-seg digits, switches, buttons).
- Decodes each CPU access by address and forwards writes to the selected target.
- Holds the LED and digit output registers.
- Returns read data with a fixed 1-cycle latency, so the registered peripheral reads line up with the synchronous DRAM read.
- Flags and counts accesses to unmapped addresses.

---
 rtl/mmio_bridge.sv | 157 +++++++++++++++
 tb/tb_mmio_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU data accesses into DRAM, timer and local I/O registers (LED, digits, switches, buttons).
// Latency: writes land at the next clk edge; read data and cpu_rvalid return exactly 1 cycle after the read strobe.
// Backpressure: none; one access is accepted every cycle and reads may issue back-to-back without stalling.
module mmio_bridge #(
    parameter logic [31:0] PERI_BASE  = 32'hFFFF_F000,
    parameter logic [31:0] ADDR_DIG   = 32'hFFFF_F000,
    parameter logic [31:0] ADDR_TIMER = 32'hFFFF_F020,
    parameter logic [31:0] ADDR_LED   = 32'hFFFF_F060,
    parameter logic [31:0] ADDR_SW    = 32'hFFFF_F070,
    parameter logic [31:0] ADDR_BTN   = 32'hFFFF_F078,
    parameter int          DRAM_AW    = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_we,
    input  logic               cpu_re,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_rvalid,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    output logic [31:0]        timer_addr,
    output logic               timer_we,
    output logic [31:0]        timer_wdata,
    input  logic [31:0]        timer_rdata,
    input  logic [23:0]        sw_in,
    input  logic [4:0]         btn_in,
    output logic [23:0]        led_out,
    output logic [31:0]        dig_out,
    output logic               bus_err,
    output logic [7:0]         err_cnt
);

    // Target select codes; SEL_UNMAP doubles as "nothing decoded".
    localparam logic [2:0] SEL_UNMAP = 3'd0;
    localparam logic [2:0] SEL_DRAM  = 3'd1;
    localparam logic [2:0] SEL_TIMER = 3'd2;
    localparam logic [2:0] SEL_LED   = 3'd3;
    localparam logic [2:0] SEL_DIG   = 3'd4;
    localparam logic [2:0] SEL_SW    = 3'd5;
    localparam logic [2:0] SEL_BTN   = 3'd6;

    // Registered read response held between the accept cycle and the response cycle.
    typedef struct packed {
        logic        pend;
        logic        is_dram;
        logic [31:0] val;
    } rd_pipe_t;

    logic [29:0] word;
    logic [2:0]  sel;
    logic        wr_acc;
    logic        rd_acc;
    logic        unmapped_hit;
    logic [31:0] peri_val;
    rd_pipe_t    rd_q;
    logic [31:0] rdata_hold;

    // Byte offset is irrelevant to every decision, so only the word address is compared.
    assign word = cpu_addr[31:2];

    // A simultaneous read+write is a write; the read half is dropped.
    assign wr_acc       = cpu_we;
    assign rd_acc       = cpu_re & ~cpu_we;
    assign unmapped_hit = (cpu_we | cpu_re) & (sel == SEL_UNMAP);

    // Address decode: below the I/O base is DRAM, otherwise an exact register match or unmapped.
    always_comb begin
        sel = SEL_UNMAP;
        if (word < PERI_BASE[31:2])
            sel = SEL_DRAM;
        else if (word == ADDR_DIG[31:2])
            sel = SEL_DIG;
        else if (word == ADDR_TIMER[31:2])
            sel = SEL_TIMER;
        else if (word == ADDR_LED[31:2])
            sel = SEL_LED;
        else if (word == ADDR_SW[31:2])
            sel = SEL_SW;
        else if (word == ADDR_BTN[31:2])
            sel = SEL_BTN;
    end

    // Peripheral read value captured in the accept cycle; DRAM and unmapped contribute 0 here.
    always_comb begin
        peri_val = 32'h0;
        case (sel)
            SEL_TIMER: peri_val = timer_rdata;
            SEL_LED:   peri_val = {8'h0, led_out};
            SEL_DIG:   peri_val = dig_out;
            SEL_SW:    peri_val = {8'h0, sw_in};
            SEL_BTN:   peri_val = {27'h0, btn_in};
            default:   peri_val = 32'h0;
        endcase
    end

    // Downstream strobes and pass-through buses; write enables only reach the selected target.
    assign dram_addr   = cpu_addr[DRAM_AW+1:2];
    assign dram_we     = wr_acc & (sel == SEL_DRAM);
    assign dram_wdata  = cpu_wdata;
    assign timer_addr  = cpu_addr;
    assign timer_we    = wr_acc & (sel == SEL_TIMER);
    assign timer_wdata = cpu_wdata;

    // Read pipeline stage: remember whether a read is due and where its data comes from.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q.pend    <= rd_acc;
            rd_q.is_dram <= rd_acc & (sel == SEL_DRAM);
            rd_q.val     <= rd_acc ? peri_val : 32'h0;
        end
    end

    assign cpu_rvalid = rd_q.pend;

    // DRAM data is only valid in the response cycle, so it is muxed live; otherwise the last response is held.
    assign cpu_rdata = rd_q.pend ? (rd_q.is_dram ? dram_rdata : rd_q.val) : rdata_hold;

    // Keep the last delivered response so cpu_rdata is stable between responses.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_hold <= 32'h0;
        else if (rd_q.pend)
            rdata_hold <= cpu_rdata;
    end

    // LED and digit output registers, loaded by CPU writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= 24'h0;
            dig_out <= 32'h0;
        end else if (wr_acc) begin
            if (sel == SEL_LED)
                led_out <= cpu_wdata[23:0];
            if (sel == SEL_DIG)
                dig_out <= cpu_wdata;
        end
    end

    // Sticky error flag and saturating counter for accesses to unmapped I/O addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
            err_cnt <= 8'h0;
        end else if (unmapped_hit) begin
            bus_err <= 1'b1;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed and randomized accesses checked against a transaction-level reference model.
// Latency: model predicts the response one cycle after each read strobe.
// Backpressure: none on the DUT; the bench drives one access per cycle.
module tb_mmio_bridge;

    localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    localparam int K_DRAM  = 0;
    localparam int K_DIG   = 1;
    localparam int K_TIMER = 2;
    localparam int K_LED   = 3;
    localparam int K_SW    = 4;
    localparam int K_BTN   = 5;
    localparam int K_UNM   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [31:0] timer_addr;
    logic        timer_we;
    logic [31:0] timer_wdata;
    logic [31:0] timer_rdata;
    logic [23:0] sw_in;
    logic [4:0]  btn_in;
    logic [23:0] led_out;
    logic [31:0] dig_out;
    logic        bus_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in synchronous DRAM device
    logic [31:0] dram_mem [0:16383];

    // Reference model state
    logic [31:0] m_mem [0:16383];
    logic [23:0] m_led;
    logic [31:0] m_dig;
    logic        m_err;
    int          m_cnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mmio_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .timer_addr(timer_addr), .timer_we(timer_we), .timer_wdata(timer_wdata), .timer_rdata(timer_rdata),
        .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .dig_out(dig_out),
        .bus_err(bus_err), .err_cnt(err_cnt)
    );

    always @(posedge clk) begin
        if (dram_we)
            dram_mem[dram_addr] <= dram_wdata;
        dram_rdata <= dram_mem[dram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'hFFFF_F000) return K_DRAM;
        if (w == A_DIG)   return K_DIG;
        if (w == A_TIMER) return K_TIMER;
        if (w == A_LED)   return K_LED;
        if (w == A_SW)    return K_SW;
        if (w == A_BTN)   return K_BTN;
        return K_UNM;
    endfunction

    // One bus cycle: drive, check decode outputs, advance model, clock, check registered outputs.
    task automatic step(input logic r, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] tmr, input logic [23:0] sw, input logic [4:0] btn);
        int k;
        int idx;
        rst = r; cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
        timer_rdata = tmr; sw_in = sw; btn_in = btn;
        #2;
        k   = classify(addr);
        idx = int'((addr / 4) % 16384);
        check_eq("dram_we",     {31'h0, dram_we},  {31'h0, (we && k == K_DRAM)});
        check_eq("timer_we",    {31'h0, timer_we}, {31'h0, (we && k == K_TIMER)});
        check_eq("dram_addr",   {18'h0, dram_addr}, idx);
        check_eq("dram_wdata",  dram_wdata,  wdata);
        check_eq("timer_addr",  timer_addr,  addr);
        check_eq("timer_wdata", timer_wdata, wdata);
        if (r) begin
            m_led = 0; m_dig = 0; m_err = 0; m_cnt = 0; m_rvalid = 0; m_rdata = 0;
        end else begin
            m_rvalid = 0;
            if (we) begin
                case (k)
                    K_DRAM: m_mem[idx] = wdata;
                    K_LED:  m_led = wdata[23:0];
                    K_DIG:  m_dig = wdata;
                    default: ;
                endcase
            end else if (re) begin
                m_rvalid = 1;
                case (k)
                    K_DRAM:  m_rdata = m_mem[idx];
                    K_TIMER: m_rdata = tmr;
                    K_LED:   m_rdata = 32'(m_led);
                    K_DIG:   m_rdata = m_dig;
                    K_SW:    m_rdata = 32'(sw);
                    K_BTN:   m_rdata = 32'(btn);
                    default: m_rdata = 0;
                endcase
            end
            if ((we || re) && k == K_UNM) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("rvalid",  {31'h0, cpu_rvalid}, {31'h0, m_rvalid});
        check_eq("rdata",   cpu_rdata, m_rdata);
        check_eq("led_out", {8'h0, led_out}, {8'h0, m_led});
        check_eq("dig_out", dig_out, m_dig);
        check_eq("bus_err", {31'h0, bus_err}, {31'h0, m_err});
        check_eq("err_cnt", {24'h0, err_cnt}, m_cnt);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0, $urandom, 24'($urandom), 5'($urandom));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int sel;
        for (int i = 0; i < 16384; i++) begin
            v = $urandom;
            dram_mem[i] = v;
            m_mem[i]    = v;
        end
        dram_mem[16] = 32'hDEADBEEF;
        m_mem[16]    = 32'hDEADBEEF;
        rst = 1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
        timer_rdata = 0; sw_in = 0; btn_in = 0;
        m_led = 0; m_dig = 0; m_err = 0; m_cnt = 0; m_rvalid = 0; m_rdata = 0;

        // Reset held 2 cycles while an LED write is presented
        step(1, 1, 0, A_LED, 32'hFFFF_FFFF, 0, 0, 0);
        step(1, 1, 0, A_LED, 32'hFFFF_FFFF, 0, 0, 0);
        idle();
        check_eq("rst_led",    {8'h0, led_out}, 32'h0);
        check_eq("rst_errcnt", {24'h0, err_cnt}, 32'h0);
        check_eq("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);

        // LED write then read
        step(0, 1, 0, A_LED, 32'h12AB_CDEF, 0, 0, 0);
        check_eq("tp_led", {8'h0, led_out}, 32'h00AB_CDEF);
        step(0, 0, 1, A_LED, 0, 0, 0, 0);
        check_eq("tp_led_rv", {31'h0, cpu_rvalid}, 32'h1);
        check_eq("tp_led_rd", cpu_rdata, 32'h00AB_CDEF);

        // DRAM read of word 0x10
        step(0, 0, 1, 32'h0000_0040, 0, 0, 0, 0);
        check_eq("tp_dram_rd", cpu_rdata, 32'hDEAD_BEEF);
        idle();
        check_eq("tp_hold", cpu_rdata, 32'hDEAD_BEEF);

        // Timer then switches, back-to-back
        step(0, 0, 1, A_TIMER, 0, 32'd7, 24'h00_0F0F, 0);
        check_eq("tp_tmr_rd", cpu_rdata, 32'd7);
        step(0, 0, 1, A_SW, 0, 32'd7, 24'h00_0F0F, 0);
        check_eq("tp_sw_rv", {31'h0, cpu_rvalid}, 32'h1);
        check_eq("tp_sw_rd", cpu_rdata, 32'h0000_0F0F);
        step(0, 1, 0, A_TIMER, 32'h55, 32'd7, 0, 0);
        idle();

        // Read presented together with reset is dropped; read then reset is cleared
        step(1, 0, 1, A_LED, 0, 0, 0, 0);
        step(0, 1, 0, A_DIG, 32'hCAFE_0001, 0, 0, 0);
        step(0, 0, 1, A_DIG, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Unmapped read then 300 unmapped writes
        step(0, 1, 0, A_LED, 32'h0033_2211, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_F100, 0, 0, 0, 0);
        check_eq("tp_unm_rd",  cpu_rdata, 32'h0);
        check_eq("tp_unm_err", {31'h0, bus_err}, 32'h1);
        check_eq("tp_unm_cnt", {24'h0, err_cnt}, 32'h1);
        for (int i = 0; i < 300; i++)
            step(0, 1, 0, 32'hFFFF_F100 + 32'(i * 4), $urandom, 0, 0, 0);
        check_eq("tp_sat_cnt", {24'h0, err_cnt}, 32'hFF);
        check_eq("tp_sat_led", {8'h0, led_out}, 32'h0033_2211);

        // Simultaneous strobes are a write only
        step(0, 1, 1, A_DIG, 32'h5A5A_5A5A, 0, 0, 0);
        check_eq("tp_both_dig", dig_out, 32'h5A5A_5A5A);
        check_eq("tp_both_rv",  {31'h0, cpu_rvalid}, 32'h0);

        // Randomized traffic from a fresh reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = {18'h0, 14'($urandom)} & 32'h0000_00FF;
                3:       a = A_DIG;
                4:       a = A_TIMER;
                5:       a = A_LED;
                6:       a = A_SW;
                7:       a = A_BTN;
                8:       a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
                default: a = $urandom & 32'hFFFF_EFFF;
            endcase
            a = (a & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            step(0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom, 24'($urandom), 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
